// File: rtl/axis_frame_len.sv
// AXI-stream framer: tags every cfg_len-th accepted beat (or an upstream last) as
// end-of-frame, with all outputs driven from a two-entry skid buffer.
module axis_frame_len #(
    parameter int DATA_WIDTH = 24,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [DATA_WIDTH-1:0] up_data,
    input  logic                  up_last,
    input  logic                  up_val,
    output logic                  up_rdy,
    output logic [DATA_WIDTH-1:0] dn_data,
    output logic                  dn_last,
    output logic                  dn_val,
    input  logic                  dn_rdy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    buf_state_t state, state_next;

    logic [LEN_WIDTH-1:0]  cnt;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH-1:0]  eff_len;
    logic                  tag;
    logic                  accept;
    logic                  emit;
    logic                  load_out_up;
    logic                  load_out_skid;
    logic                  load_skid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_last;

    assign accept = up_val & up_rdy;
    assign emit   = dn_val & dn_rdy;
    assign dn_val = (state != EMPTY);

    // The first beat of a frame compares against cfg_len directly, later beats
    // against the value latched on that first beat.
    assign eff_len = (cnt == '0) ? cfg_len : len;
    assign tag     = up_last | ((eff_len != '0) && (cnt == eff_len - 1'b1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            len <= '0;
        end else if (accept) begin
            if (cnt == '0)
                len <= cfg_len;
            cnt <= tag ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        state_next    = state;
        load_out_up   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next  = ONE;
                    load_out_up = 1'b1;
                end
            end
            ONE: begin
                if (accept && emit) begin
                    load_out_up = 1'b1;
                end else if (accept) begin
                    state_next = TWO;
                    load_skid  = 1'b1;
                end else if (emit) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (emit) begin
                    state_next    = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // up_rdy is a flop so it stays low through reset and rises one edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= EMPTY;
            up_rdy <= 1'b0;
        end else begin
            state  <= state_next;
            up_rdy <= (state_next != TWO);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dn_data <= '0;
            dn_last <= 1'b0;
        end else if (load_out_up) begin
            dn_data <= up_data;
            dn_last <= tag;
        end else if (load_out_skid) begin
            dn_data <= skid_data;
            dn_last <= skid_last;
        end
    end

    // Skid contents are only meaningful while state is TWO, so no reset is needed.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_data <= up_data;
            skid_last <= tag;
        end
    end

endmodule

// File: tb/tb_axis_frame_len.sv
// Randomized and directed bench for axis_frame_len against a frame-level
// reference model (expected-beat queue plus position-in-frame tracking).
module tb_axis_frame_len;

    localparam int DW = 24;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [LW-1:0] cfg_len;
    logic [DW-1:0] up_data;
    logic          up_last;
    logic          up_val;
    logic          up_rdy;
    logic [DW-1:0] dn_data;
    logic          dn_last;
    logic          dn_val;
    logic          dn_rdy;

    axis_frame_len #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_len (cfg_len),
        .up_data (up_data),
        .up_last (up_last),
        .up_val  (up_val),
        .up_rdy  (up_rdy),
        .dn_data (dn_data),
        .dn_last (dn_last),
        .dn_val  (dn_val),
        .dn_rdy  (dn_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t q[$];
    int    pos;
    int    flen;
    int    tests = 0;
    int    fails = 0;
    bit    rdy_ok;
    int    next_d;
    bit    last_seen [0:255];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: position within the current frame and the length
    // captured when that frame began; positions wrap at 2**LW.
    function automatic void model_accept(input logic [DW-1:0] d, input logic l);
        bit e;
        if (pos == 0)
            flen = int'(cfg_len);
        e = l || (flen != 0 && pos + 1 == flen);
        q.push_back('{d, e});
        pos = e ? 0 : (pos + 1) % (1 << LW);
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit v, input bit l, input logic [DW-1:0] d, input bit r);
        up_val  = v;
        up_last = l;
        up_data = d;
        dn_rdy  = r;
        #1;
        check("dn_val", 32'(dn_val), 32'(q.size() != 0));
        check("up_rdy", 32'(up_rdy), 32'(rdy_ok && q.size() < 2));
        if (dn_val && q.size() != 0) begin
            check("dn_data", 32'(dn_data), 32'(q[0].d));
            check("dn_last", 32'(dn_last), 32'(q[0].l));
        end
        if (dn_val && dn_rdy && q.size() != 0) begin
            last_seen[dn_data[7:0]] = dn_last;
            void'(q.pop_front());
        end
        if (up_val && up_rdy) begin
            model_accept(d, l);
            next_d++;
        end
        @(negedge clk);
        rdy_ok = 1'b1;
    endtask

    // Asserts reset asynchronously mid-cycle, holds it n (>=1) falling edges.
    task automatic do_reset(input int n);
        rst     = 1'b0;
        up_val  = 1'b1;
        up_last = 1'b0;
        dn_rdy  = 1'b1;
        #1;
        q.delete();
        pos  = 0;
        flen = 0;
        check("rst_dn_data", 32'(dn_data), 32'd0);
        check("rst_dn_last", 32'(dn_last), 32'd0);
        check("rst_dn_val", 32'(dn_val), 32'd0);
        check("rst_up_rdy", 32'(up_rdy), 32'd0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_hold_up_rdy", 32'(up_rdy), 32'd0);
            check("rst_hold_dn_val", 32'(dn_val), 32'd0);
        end
        rst    = 1'b1;
        rdy_ok = 1'b0;
        next_d = 1;
        foreach (last_seen[i]) last_seen[i] = 1'b0;
    endtask

    task automatic send_until(input int n, input int last_beat);
        int g;
        g = 0;
        while (next_d <= n && g < 400) begin
            step(1'b1, next_d == last_beat, DW'(next_d), 1'b1);
            g++;
        end
        if (next_d <= n)
            check("send_timeout", 32'(next_d), 32'(n + 1));
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0, 1'b0, '0, 1'b1);
        check("drain_empty", 32'(dn_val), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        cfg_len = '0;
        up_data = '0;
        up_last = 1'b0;
        up_val  = 1'b0;
        dn_rdy  = 1'b0;
        rdy_ok  = 1'b0;
        next_d  = 1;
        @(negedge clk);
        do_reset(6);

        // Fixed framing
        cfg_len = 4'd4;
        send_until(12, 0);
        drain(4);
        for (int i = 1; i <= 12; i++)
            check("fix_last", 32'(last_seen[i]), 32'(i % 4 == 0));

        // Early termination restarts the count
        do_reset(1);
        cfg_len = 4'd8;
        send_until(12, 3);
        drain(4);
        for (int i = 1; i <= 12; i++)
            check("early_last", 32'(last_seen[i]), 32'(i == 3 || i == 11));

        // Mid-frame config change takes effect at the next frame
        do_reset(1);
        for (int g = 0; g < 100 && next_d <= 10; g++) begin
            cfg_len = (next_d <= 2) ? 4'd5 : 4'd2;
            step(1'b1, 1'b0, DW'(next_d), 1'b1);
        end
        drain(4);
        for (int i = 1; i <= 10; i++)
            check("cfg_last", 32'(last_seen[i]), 32'(i == 5 || i == 7 || i == 9));

        // Backpressure: stall, then toggle dn_rdy
        do_reset(1);
        cfg_len = 4'd3;
        repeat (10) step(1'b1, 1'b0, DW'(next_d), 1'b0);
        check("bp_up_rdy_low", 32'(up_rdy), 32'd0);
        check("bp_dn_val", 32'(dn_val), 32'd1);
        check("bp_depth", 32'(next_d - 1), 32'd2);
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b0, DW'(next_d), i % 2 == 1);
        send_until(15, 0);
        drain(4);
        for (int i = 1; i <= 15; i++)
            check("bp_last", 32'(last_seen[i]), 32'(i % 3 == 0));

        // Disabled framing; 32 beats brings the counter back to a frame start
        do_reset(1);
        cfg_len = 4'd0;
        send_until(20, 0);
        drain(3);
        send_until(32, 0);
        cfg_len = 4'd1;
        send_until(40, 0);
        drain(4);
        for (int i = 1; i <= 40; i++)
            check("dis_last", 32'(last_seen[i]), 32'(i > 32));

        // Reset mid-frame discards buffered beats and the partial count
        do_reset(1);
        cfg_len = 4'd5;
        repeat (3) step(1'b1, 1'b0, DW'(next_d), 1'b0);
        do_reset(2);
        cfg_len = 4'd3;
        send_until(6, 0);
        drain(4);
        for (int i = 1; i <= 6; i++)
            check("mid_rst_last", 32'(last_seen[i]), 32'(i == 3 || i == 6));

        // Randomized traffic against the model
        do_reset(1);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 49) == 0)
                cfg_len = LW'($urandom_range(0, 6));
            if ($urandom_range(0, 399) == 0)
                do_reset(1);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 DW'($urandom), $urandom_range(0, 2) != 0);
        end
        drain(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
